// File: rtl/dup_chk_pkg.sv
// Shared constants, output-register state type and popcount helper for the
// duplicate-path checker.
package dup_chk_pkg;

   localparam int unsigned MODE_COMPL = 0;
   localparam int unsigned MODE_UNIF  = 1;

   typedef enum logic [0:0] {ST_EMPTY, ST_FULL} out_state_e;

   function automatic logic [3:0] popcount8(input logic [7:0] d);
      logic [3:0] cnt;
      cnt = 4'd0;
      for (int i = 0; i < 8; i++) begin
         cnt = cnt + {3'b000, d[i]};
      end
      return cnt;
   endfunction

endpackage

// File: rtl/dup_chk_if.sv
// Sample input and byte output handshake of the duplicate-path checker.
interface dup_chk_if;
   logic [7:0] x;
   logic       in_valid;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;

   modport master (
      output x, in_valid, out_ready,
      input  out_data, out_valid
   );

   modport slave (
      input  x, in_valid, out_ready,
      output out_data, out_valid
   );
endinterface

// File: rtl/dup_vote.sv
// Combinational normalise + majority vote of one duplicated-bit word.
// A tie resolves to the normalised MSB.
module dup_vote
   import dup_chk_pkg::*;
#(
   parameter int unsigned MODE = MODE_COMPL
) (
   input  logic [7:0] x_i,
   output logic       v_o,
   output logic       mismatch_o
);

   logic [7:0] n;
   logic [3:0] p;
   logic       v;

   always_comb begin
      n = (MODE == MODE_UNIF) ? x_i : {x_i[7:4], ~x_i[3:0]};
      p = popcount8(n);
      if (p >= 4'd5) begin
         v = 1'b1;
      end else if (p <= 4'd3) begin
         v = 1'b0;
      end else begin
         v = n[7];
      end
      v_o        = v;
      mismatch_o = (n != {8{v}});
   end

endmodule

// File: rtl/dup_chk.sv
// Duplicate-path checker: votes each sample, counts mismatches, and packs
// voted bits MSB-first into bytes on a valid/ready output register.
module dup_chk
   import dup_chk_pkg::*;
#(
   parameter int unsigned MODE  = MODE_COMPL,
   parameter int unsigned ERR_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   dup_chk_if.slave         bus,
   output logic             err_sticky,
   output logic             ovf_sticky,
   output logic [ERR_W-1:0] err_cnt
);

   localparam logic [ERR_W-1:0] CntMax = '1;
   localparam logic [ERR_W-1:0] CntOne = ERR_W'(1);

   logic             v;
   logic             mis;
   logic [2:0]       idx_q, idx_d;
   logic [6:0]       sh_q, sh_d;
   logic             complete;
   logic [7:0]       new_byte;
   out_state_e       state_q, state_d;
   logic [7:0]       data_q, data_d;
   logic             load;
   logic             drop;
   logic [ERR_W-1:0] err_q, err_d;
   logic             es_q, es_d;
   logic             os_q, os_d;

   dup_vote #(
      .MODE (MODE)
   ) u_vote (
      .x_i        (bus.x),
      .v_o        (v),
      .mismatch_o (mis)
   );

   always_comb begin
      idx_d    = idx_q;
      sh_d     = sh_q;
      complete = 1'b0;
      if (bus.in_valid) begin
         idx_d    = idx_q + 3'd1;
         sh_d     = {sh_q[5:0], v};
         complete = (idx_q == 3'd7);
      end
   end

   assign new_byte = {sh_q, v};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_EMPTY: if (complete) state_d = ST_FULL;
         ST_FULL:  if (bus.out_ready && !complete) state_d = ST_EMPTY;
      endcase
   end

   // A byte completing while FULL is only taken if the old one leaves this cycle.
   always_comb begin
      bus.out_valid = (state_q == ST_FULL);
      load          = complete && ((state_q == ST_EMPTY) || bus.out_ready);
      drop          = complete && (state_q == ST_FULL) && !bus.out_ready;
   end

   assign data_d = load ? new_byte : data_q;

   always_comb begin
      err_d = err_q;
      es_d  = es_q;
      os_d  = os_q;
      if (clr) begin
         err_d = '0;
         es_d  = 1'b0;
         os_d  = 1'b0;
      end else begin
         if (bus.in_valid && mis) begin
            es_d = 1'b1;
            if (err_q != CntMax) err_d = err_q + CntOne;
         end
         if (drop) os_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_q  <= 3'd0;
         sh_q   <= 7'd0;
         data_q <= 8'd0;
         err_q  <= '0;
         es_q   <= 1'b0;
         os_q   <= 1'b0;
      end else begin
         idx_q  <= idx_d;
         sh_q   <= sh_d;
         data_q <= data_d;
         err_q  <= err_d;
         es_q   <= es_d;
         os_q   <= os_d;
      end
   end

   assign bus.out_data = data_q;
   assign err_cnt      = err_q;
   assign err_sticky   = es_q;
   assign ovf_sticky   = os_q;

endmodule
